ps2_scancode_rx: RTL and testbench

- Receives PS/2 keyboard frames (11-bit, device-clocked) on the ps2_clk/ps2_data pins.
- Decodes them into Set-2 scan codes and resolves the 0xF0 (break) and 0xE0 (extended) prefixes.
- Holds the last make code on an 8-bit bus that feeds the seven-segment character decoder directly downstream, and also emits per-key event pulses.

---
 rtl/ps2_scancode_rx.sv | 176 +++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes and glitch-filters the device clock, deframes
// 11-bit frames, resolves the 0xF0/0xE0 prefixes and emits per-key events.
// Optional build macro PS2_TYPEMATIC_FILTER_EN suppresses auto-repeated make events.
module ps2_scancode_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       frame_err
);

    localparam int unsigned FltW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic            clk_s1_q, clk_s2_q;
    logic            dat_s1_q, dat_s2_q;
    logic            filt_q;
    logic [FltW-1:0] flt_cnt_q;
    logic            fe_q;

    state_e          state_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            par_q;
    logic [TmoW-1:0] tmo_q;
    logic            brk_pending_q;
    logic            ext_pending_q;

    logic            frame_ok;
    logic            tmo_hit;
    logic            suppress;

    // Stop bit must be 1 and data+parity must carry an odd number of ones.
    assign frame_ok = dat_s2_q && (^{shift_q, par_q});
    assign tmo_hit  = (state_q != StIdle) && !fe_q && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       last_vld_q;
    logic [7:0] last_code_q;
    logic       last_ext_q;
    logic       repeat_hit;

    assign repeat_hit = last_vld_q && (last_code_q == shift_q) && (last_ext_q == ext_pending_q);
    assign suppress   = !brk_pending_q && repeat_hit;

    // Remember the held key; a matching break releases it so the next make is reported.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_vld_q  <= 1'b0;
            last_code_q <= 8'h00;
            last_ext_q  <= 1'b0;
        end else if (fe_q && state_q == StStop && frame_ok &&
                     shift_q != 8'hF0 && shift_q != 8'hE0) begin
            if (brk_pending_q) begin
                if (repeat_hit) last_vld_q <= 1'b0;
            end else begin
                last_vld_q  <= 1'b1;
                last_code_q <= shift_q;
                last_ext_q  <= ext_pending_q;
            end
        end
    end
`else
    assign suppress = 1'b0;
`endif

    // Two-flop synchronizers, then a level filter that needs FILTER_LEN agreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            filt_q    <= 1'b1;
            flt_cnt_q <= '0;
            fe_q      <= 1'b0;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
            fe_q     <= 1'b0;
            if (clk_s2_q == filt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FltW'(FILTER_LEN - 1)) begin
                filt_q    <= clk_s2_q;
                flt_cnt_q <= '0;
                fe_q      <= ~clk_s2_q;
            end else begin
                flt_cnt_q <= flt_cnt_q + 1'b1;
            end
        end
    end

    // Frame FSM with timeout, prefix tracking and registered event outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            par_q         <= 1'b0;
            tmo_q         <= '0;
            brk_pending_q <= 1'b0;
            ext_pending_q <= 1'b0;
            code          <= 8'h00;
            key_valid     <= 1'b0;
            key_code      <= 8'h00;
            key_break     <= 1'b0;
            key_ext       <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            if (state_q == StIdle || fe_q) tmo_q <= '0;
            else                           tmo_q <= tmo_q + 1'b1;

            if (tmo_hit) begin
                frame_err     <= 1'b1;
                state_q       <= StIdle;
                brk_pending_q <= 1'b0;
                ext_pending_q <= 1'b0;
            end else if (fe_q) begin
                unique case (state_q)
                    StIdle: begin
                        if (!dat_s2_q) begin
                            state_q   <= StData;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    StData: begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= StParity;
                    end
                    StParity: begin
                        par_q   <= dat_s2_q;
                        state_q <= StStop;
                    end
                    StStop: begin
                        state_q <= StIdle;
                        if (!frame_ok) begin
                            frame_err     <= 1'b1;
                            brk_pending_q <= 1'b0;
                            ext_pending_q <= 1'b0;
                        end else if (shift_q == 8'hF0) begin
                            brk_pending_q <= 1'b1;
                        end else if (shift_q == 8'hE0) begin
                            ext_pending_q <= 1'b1;
                        end else begin
                            brk_pending_q <= 1'b0;
                            ext_pending_q <= 1'b0;
                            if (!suppress) begin
                                key_valid <= 1'b1;
                                key_code  <= shift_q;
                                key_break <= brk_pending_q;
                                key_ext   <= ext_pending_q;
                                if (!brk_pending_q) code <= shift_q;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: stimulus pushes expected events, a monitor pops them.
module tb_ps2_scancode_rx;

    localparam int unsigned FLT  = 4;
    localparam int unsigned TMO  = 2000;
    localparam int unsigned HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_break;
    logic       key_ext;
    logic       frame_err;

    ps2_scancode_rx #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .code      (code),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_break (key_break),
        .key_ext   (key_ext),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        logic [7:0] kc;
        bit         brk;
        bit         ext;
        logic [7:0] code;
    } ev_t;

    ev_t q[$];
    int  vectors = 0;
    int  miscompares = 0;

    // Reference model state: what the keyboard protocol says the receiver should hold.
    logic [7:0] m_code = 8'h00;
    bit         m_brk = 0, m_ext = 0;
    bit         lm_vld = 0;
    logic [7:0] lm_code = 8'h00;
    bit         lm_ext = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_code = 8'h00; m_brk = 0; m_ext = 0; lm_vld = 0;
    endfunction

    function automatic void model_err();
        ev_t e;
        m_brk = 0; m_ext = 0;
        e.err = 1; e.kc = 8'h00; e.brk = 0; e.ext = 0; e.code = m_code;
        q.push_back(e);
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        ev_t e;
        bit  emit;
        bit  same;
        if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else begin
            emit = 1;
            same = lm_vld && lm_code == b && lm_ext == m_ext;
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (!m_brk && same) emit = 0;
            else if (m_brk && same) lm_vld = 0;
            else if (!m_brk) begin lm_vld = 1; lm_code = b; lm_ext = m_ext; end
`else
            if (!m_brk) begin lm_vld = 1; lm_code = b; lm_ext = m_ext; end
            if (same) emit = 1;
`endif
            if (emit) begin
                if (!m_brk) m_code = b;
                e.err = 0; e.kc = b; e.brk = m_brk; e.ext = m_ext; e.code = m_code;
                q.push_back(e);
            end
            m_brk = 0; m_ext = 0;
        end
    endfunction

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Full frame; expectation is queued just before the stop-bit edge.
    task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop_val);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ par_flip);
        if (!par_flip && stop_val) model_byte(b);
        else                       model_err();
        ps2_bit(stop_val);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_partial(input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 4 * TMO) begin
            @(negedge clk);
            n++;
        end
        chk(name, q.size(), 0);
    endtask

    // Monitor: every DUT event must match the oldest queued expectation.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (key_valid || frame_err) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_event: got key_valid=%0b frame_err=%0b, expected none at %0t",
                             key_valid, frame_err, $time);
                end else begin
                    e = q.pop_front();
                    chk("ev_frame_err", 32'(frame_err), 32'(e.err));
                    chk("ev_key_valid", 32'(key_valid), 32'(!e.err));
                    chk("ev_code", 32'(code), 32'(e.code));
                    if (!e.err) begin
                        chk("ev_key_code", 32'(key_code), 32'(e.kc));
                        chk("ev_key_break", 32'(key_break), 32'(e.brk));
                        chk("ev_key_ext", 32'(key_ext), 32'(e.ext));
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [7:0] k;
        logic [7:0] prev;
        int         r;
        prev = 8'h1C;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_code", 32'(code), 0);
        chk("rst_key_code", 32'(key_code), 0);
        chk("rst_key_valid", 32'(key_valid), 0);
        chk("rst_key_break", 32'(key_break), 0);
        chk("rst_key_ext", 32'(key_ext), 0);
        chk("rst_frame_err", 32'(frame_err), 0);

        send_frame(8'h1C, 0, 1);
        send_frame(8'hF0, 0, 1);
        send_frame(8'h1C, 0, 1);
        send_frame(8'hE0, 0, 1);
        send_frame(8'h75, 0, 1);
        send_frame(8'h45, 0, 1);
        send_frame(8'h16, 1, 1);
        send_frame(8'h16, 0, 1);
        send_frame(8'h16, 0, 0);
        wait_drain("drain_directed");

        send_partial(5);
        model_err();
        repeat (TMO + 200) @(negedge clk);
        wait_drain("drain_timeout");
        send_frame(8'h45, 0, 1);

        send_frame(8'h1C, 0, 1);
        send_frame(8'h1C, 0, 1);
        send_frame(8'h1C, 0, 1);
        send_frame(8'hF0, 0, 1);
        send_frame(8'h1C, 0, 1);
        send_frame(8'h1C, 0, 1);
        wait_drain("drain_typematic");

        send_partial(3);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midrst_code", 32'(code), 0);
        chk("midrst_key_code", 32'(key_code), 0);
        chk("midrst_key_valid", 32'(key_valid), 0);
        chk("midrst_frame_err", 32'(frame_err), 0);
        repeat (TMO + 200) @(negedge clk);
        send_frame(8'h45, 0, 1);

        for (int it = 0; it < 50; it++) begin
            r = $urandom_range(0, 9);
            k = 8'($urandom_range(1, 8'h83));
            case (r)
                0: send_frame(k, 1, 1);
                1: send_frame(k, 0, 0);
                2: send_frame(prev, 0, 1);
                default: begin
                    if ($urandom_range(0, 2) == 0) send_frame(8'hE0, 0, 1);
                    if ($urandom_range(0, 2) == 0) send_frame(8'hF0, 0, 1);
                    send_frame(k, 0, 1);
                    prev = k;
                end
            endcase
        end
        wait_drain("drain_random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
